num_screen_scan: RTL
====================

// Module: num_screen_scan
// PURPOSE
//  Parametrised multiplexed 7-segment display driver; generalises the fixed 8-digit numeric screen.
//  Per-digit hex decode, dot, enable and blink. Leading-zero suppression, PWM brightness and inter-digit blanking.
//  Double-buffered: loads are staged and applied only at frame boundaries, so the display never tears.
//  Drives the board anode/segment pins directly; sits between application logic and top-level I/O.
// PARAMETERS
//  DIGITS       8       number of digits scanned, 1..16
//  SCAN_DIV     100000  clock cycles per digit slot, >= BLANK_CYC+2
//  BLANK_CYC    16      cycles at start of each slot with all digits off (anti-ghosting), >= 0
//  BLINK_FRAMES 64      frames per blink half-period, >= 1
//  BW           3       brightness field width, 1..8
// PORTS
//  clock          in   1          system clock, all logic on rising edge
//  rst            in   1          asynchronous, active-low reset
//  load           in   1          1-cycle strobe: stage en/display/dots/blink/lzs
//  en             in   DIGITS     per-digit enable
//  display        in   DIGITS*4   packed [DIGITS-1:0][3:0] hex value per digit; digit 0 = rightmost
//  dots           in   DIGITS     per-digit decimal point
//  blink          in   DIGITS     per-digit blink mask
//  lzs            in   1          leading-zero suppression enable
//  bright         in   BW         duty level; not staged, sampled every cycle
//  targeten       out  DIGITS     active-low one-hot digit select
//  targetdisplay  out  8          active-low segments {dp,g,f,e,d,c,b,a}
//  frame_start    out  1          1-cycle pulse when the digit index wraps to 0
//  pending        out  1          staged data waiting for the next frame boundary
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all counters, digit index, blink_phase and pending clear to 0.
//   - active and staged registers clear to 0.
//   - targeten='1 and targetdisplay=8'hFF (all dark).
//   - frame_start=0.
//   - Reset mid-frame discards staged data.
//  Scan:
//   - tick_cnt counts 0..SCAN_DIV-1.
//   - On wrap, idx advances 0..DIGITS-1, wrapping to 0.
//   - Frame boundary = cycle where tick_cnt wraps and idx=DIGITS-1.
//  Staging:
//   - When load=1, the stage registers capture the inputs and pending is set to 1.
//   - Later loads overwrite the stage (last wins).
//   - At a frame boundary with pending=1: active<=stage, pending<=0, and frame_start pulses in the same cycle.
//   - load on the boundary cycle: the old stage is applied; the new values are staged and pending stays 1.
//  Blink:
//   - frame counter increments at each boundary.
//   - blink_phase toggles every BLINK_FRAMES frames.
//  Lit condition for current digit i, all of:
//   - act_en[i]=1
//   - !(act_blink[i] && blink_phase)
//   - not suppressed
//   - tick_cnt >= BLANK_CYC
//   - pwm_cnt <= bright
//  Suppression:
//   - digit i (i>0) is suppressed when act_lzs=1 and every enabled digit j>=i holds value 0.
//   - Digit 0 is never suppressed.
//   - A suppressed digit's dp is also off.
//  PWM:
//   - pwm_cnt is a BW-bit free-running counter.
//   - bright=all-ones gives 100% duty; bright=0 gives 1/2^BW duty.
//  Decode: hex 0-F, standard glyphs (A,b,C,d,E,F); dp=act_dots[i].
//  Outputs:
//   - Registered; 1-cycle latency from tick_cnt/idx state to pins.
//   - When the digit is not lit: targeten='1 and targetdisplay=8'hFF.
//   - Otherwise: targeten=~(1<<i) and targetdisplay=~{dp,seg}.
// TESTING
//  Use DIGITS=4, SCAN_DIV=8, BLANK_CYC=1, BLINK_FRAMES=2, BW=2, bright=3 unless noted.
//  1. Reset, no load -> targeten=4'hF and targetdisplay=8'hFF for >=3 frames; pending=0.
//  2. load display=4'h{3,2,1,0}, en=F -> pending=1 until boundary, then frame_start pulses.
//     Next frame scans digits 0..3 with targetdisplay ~8'h3F,~06,~5B,~4F; 1 dark cycle per slot.
//  3. Second load mid-frame before boundary -> only the second data appears; load on the boundary cycle -> applied one frame later.
//  4. lzs=1, display={0,0,5,0} -> digits 3,2 dark, digit 1 shows 5, digit 0 shows 0.
//  5. blink=4'b0001 -> digit 0 dark on frames 2-3 and 6-7 and lit on frames 0-1 and 4-5; other digits steady.
//  6. bright=0 -> each digit lit 1 of 4 cycles in its slot.
//     Assert rst mid-slot -> outputs go dark immediately (async).

Source files
------------

// File: rtl/num_screen_scan.sv
// Multiplexed 7-segment scan driver with double-buffered loads,
// leading-zero suppression, blink, PWM dimming and inter-digit blanking.
module num_screen_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int BW           = 3
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DIGITS-1:0]      en,
    input  logic [DIGITS-1:0][3:0] display,
    input  logic [DIGITS-1:0]      dots,
    input  logic [DIGITS-1:0]      blink,
    input  logic                   lzs,
    input  logic [BW-1:0]          bright,
    output logic [DIGITS-1:0]      targeten,
    output logic [7:0]             targetdisplay,
    output logic                   frame_start,
    output logic                   pending
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [TW-1:0]          tick_q, tick_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [FW-1:0]          frm_q, frm_d;
    logic                   phase_q, phase_d;
    logic [BW-1:0]          pwm_q, pwm_d;
    logic                   pend_q, pend_d;
    logic                   fs_q, fs_d;
    logic [DIGITS-1:0]      ten_q, ten_d;
    logic [7:0]             tdisp_q, tdisp_d;

    logic [DIGITS-1:0]      stg_en_q, stg_en_d;
    logic [DIGITS-1:0][3:0] stg_disp_q, stg_disp_d;
    logic [DIGITS-1:0]      stg_dots_q, stg_dots_d;
    logic [DIGITS-1:0]      stg_blink_q, stg_blink_d;
    logic                   stg_lzs_q, stg_lzs_d;

    logic [DIGITS-1:0]      act_en_q, act_en_d;
    logic [DIGITS-1:0][3:0] act_disp_q, act_disp_d;
    logic [DIGITS-1:0]      act_dots_q, act_dots_d;
    logic [DIGITS-1:0]      act_blink_q, act_blink_d;
    logic                   act_lzs_q, act_lzs_d;

    logic                   tick_wrap;
    logic                   boundary;
    logic [DIGITS-1:0]      supp;
    logic                   zero_run;
    logic                   lit;
    logic [6:0]             seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'h3F;
            4'h1:    decode = 7'h06;
            4'h2:    decode = 7'h5B;
            4'h3:    decode = 7'h4F;
            4'h4:    decode = 7'h66;
            4'h5:    decode = 7'h6D;
            4'h6:    decode = 7'h7D;
            4'h7:    decode = 7'h07;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h6F;
            4'hA:    decode = 7'h77;
            4'hB:    decode = 7'h7C;
            4'hC:    decode = 7'h39;
            4'hD:    decode = 7'h5E;
            4'hE:    decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign tick_wrap = (tick_q == TW'(SCAN_DIV - 1));
    assign boundary  = tick_wrap && (idx_q == IW'(DIGITS - 1));

    always_comb begin
        tick_d      = tick_wrap ? '0 : tick_q + 1'b1;
        idx_d       = idx_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        pwm_d       = pwm_q + 1'b1;
        pend_d      = pend_q;
        fs_d        = boundary;
        stg_en_d    = stg_en_q;
        stg_disp_d  = stg_disp_q;
        stg_dots_d  = stg_dots_q;
        stg_blink_d = stg_blink_q;
        stg_lzs_d   = stg_lzs_q;
        act_en_d    = act_en_q;
        act_disp_d  = act_disp_q;
        act_dots_d  = act_dots_q;
        act_blink_d = act_blink_q;
        act_lzs_d   = act_lzs_q;
        if (tick_wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        if (boundary) begin
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
            if (pend_q) begin
                act_en_d    = stg_en_q;
                act_disp_d  = stg_disp_q;
                act_dots_d  = stg_dots_q;
                act_blink_d = stg_blink_q;
                act_lzs_d   = stg_lzs_q;
                pend_d      = 1'b0;
            end
        end
        // A load on the boundary cycle re-arms after the old stage moves out
        if (load) begin
            stg_en_d    = en;
            stg_disp_d  = display;
            stg_dots_d  = dots;
            stg_blink_d = blink;
            stg_lzs_d   = lzs;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (!act_en_q[k] || act_disp_q[k] == 4'h0);
            supp[k]  = act_lzs_q && zero_run && (k != 0);
        end
    end

    always_comb begin
        seg = decode(act_disp_q[idx_q]);
        lit = act_en_q[idx_q]
           && !(act_blink_q[idx_q] && phase_q)
           && !supp[idx_q]
           && (tick_q >= TW'(BLANK_CYC))
           && (pwm_q <= bright);
        ten_d   = lit ? ~(DIGITS'(1) << idx_q) : '1;
        tdisp_d = lit ? ~{act_dots_q[idx_q], seg} : 8'hFF;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tick_q      <= '0;
            idx_q       <= '0;
            frm_q       <= '0;
            phase_q     <= 1'b0;
            pwm_q       <= '0;
            pend_q      <= 1'b0;
            fs_q        <= 1'b0;
            ten_q       <= '1;
            tdisp_q     <= 8'hFF;
            stg_en_q    <= '0;
            stg_disp_q  <= '0;
            stg_dots_q  <= '0;
            stg_blink_q <= '0;
            stg_lzs_q   <= 1'b0;
            act_en_q    <= '0;
            act_disp_q  <= '0;
            act_dots_q  <= '0;
            act_blink_q <= '0;
            act_lzs_q   <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
            fs_q        <= fs_d;
            ten_q       <= ten_d;
            tdisp_q     <= tdisp_d;
            stg_en_q    <= stg_en_d;
            stg_disp_q  <= stg_disp_d;
            stg_dots_q  <= stg_dots_d;
            stg_blink_q <= stg_blink_d;
            stg_lzs_q   <= stg_lzs_d;
            act_en_q    <= act_en_d;
            act_disp_q  <= act_disp_d;
            act_dots_q  <= act_dots_d;
            act_blink_q <= act_blink_d;
            act_lzs_q   <= act_lzs_d;
        end
    end

    assign targeten      = ten_q;
    assign targetdisplay = tdisp_q;
    assign frame_start   = fs_q;
    assign pending       = pend_q;

endmodule
